// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the frame UART transmitter.
// Contents: FSM state enum, default frame size, ASCII constants used for
// frame termination, and byte/count widths.
package bt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    FINISH
  } state_t;

  localparam int unsigned FRAME_BYTES_DEFAULT = 18;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned COUNT_W             = 5;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/bt_frame_uart_tx_if.sv
// Frame handoff interface between the command encoder and the UART sender.
// Signals: frame_data (8*FRAME_BYTES, byte 0 in the low lane), frame_valid,
// frame_ready. master = encoder side, slave = transmitter side.
interface bt_frame_uart_tx_if #(
  parameter int unsigned FRAME_BYTES = 18
);

  logic [8*FRAME_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/bt_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and raises bit_end during the
// last cycle of every bit. clear holds the count at 0 so a bit period starts
// exactly on the cycle after clear drops.
// Ports: clk, reset (async, active-high), clear (sync), bit_end (registered).
module bt_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434,
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  // Next count wraps to 0 at the bit boundary; never exceeds LAST.
  always_comb begin
    cnt_nxt_c = cnt + CW'(1);
    if (clear || (cnt == LAST)) begin
      cnt_nxt_c = '0;
    end
  end

  // bit_end is registered from the next count so it lines up with cnt == LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt_c;
      bit_end <= (cnt_nxt_c == LAST);
    end
  end

endmodule

// File: rtl/bt_frame_uart_tx.sv
// Sends a captured command frame byte by byte as 8N1 UART. The frame ends at
// FRAME_BYTES bytes or at the first 0x00 byte, which is never sent.
// Ports: clk, reset (async, active-high), frm (slave: frame_data,
// frame_valid, frame_ready), tx (serial line, idle high), busy, done (one
// cycle at frame end), bytes_sent (bytes sent in the last/current frame).
module bt_frame_uart_tx
  import bt_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FRAME_BYTES  = FRAME_BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  bt_frame_uart_tx_if.slave  frm,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] bytes_sent
);

  localparam int unsigned FRAME_W = BYTE_W * FRAME_BYTES;

  state_t               state;
  logic [FRAME_W-1:0]   frame_buf;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 tick_clear;

  logic [FRAME_W-1:0]   buf_shift_c;
  logic [COUNT_W-1:0]   sent_inc_c;
  logic [2:0]           bit_idx_nxt_c;
  logic                 last_byte_c;

  // Timer is held at 0 outside the bit-timed states.
  assign tick_clear = (state == IDLE) || (state == FINISH);

  // Current byte always sits in frame_buf[7:0]; shifting exposes the next one.
  assign buf_shift_c   = frame_buf >> BYTE_W;
  assign sent_inc_c    = bytes_sent + COUNT_W'(1);
  assign bit_idx_nxt_c = bit_idx + 3'd1;
  assign last_byte_c   = (sent_inc_c == COUNT_W'(FRAME_BYTES)) ||
                         (buf_shift_c[BYTE_W-1:0] == ASCII_NUL);

  bt_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (tick_clear),
    .bit_end (bit_end)
  );

  // Frame sequencer; every output is registered and set for the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      frame_buf       <= '0;
      bit_idx         <= '0;
      bytes_sent      <= '0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      frm.frame_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          done <= 1'b0;
          if (frm.frame_valid) begin
            frame_buf       <= frm.frame_data;
            bytes_sent      <= '0;
            bit_idx         <= '0;
            frm.frame_ready <= 1'b0;
            if (frm.frame_data[BYTE_W-1:0] == ASCII_NUL) begin
              // Empty frame: report completion without touching the line.
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= START;
              tx    <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= frame_buf[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx_nxt_c;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= frame_buf[bit_idx_nxt_c];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            bytes_sent <= sent_inc_c;
            frame_buf  <= buf_shift_c;
            if (last_byte_c) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end else begin
              // Back-to-back bytes: next start bit follows with no idle gap.
              state <= START;
              tx    <= 1'b0;
            end
          end
        end

        FINISH: begin
          state           <= IDLE;
          done            <= 1'b0;
          tx              <= 1'b1;
          frm.frame_ready <= 1'b1;
        end

        default: begin
          state           <= IDLE;
          tx              <= 1'b1;
          busy            <= 1'b0;
          done            <= 1'b0;
          frm.frame_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
